// File: rtl/adc_frame_packer.sv
// Deserializes framed serial ADC data into 10-bit samples and packs three samples
// per 32-bit word. Scan boundaries flush partial words and enforce a per-scan word limit.
module adc_frame_packer #(
  parameter int MAX_WORDS = 4096,
  parameter int CNT_W     = 13
) (
  input  logic             rst_n,
  input  logic             rcv_clk,
  input  logic             i_fs,
  input  logic             i_d,
  input  logic             i_sync,
  output logic [31:0]      o_data,
  output logic             o_vld,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic             o_frm_err,
  output logic             o_ovf
);

  typedef enum logic {ST_IDLE, ST_SHIFT} des_state_t;

  des_state_t state, state_nxt;
  logic [3:0]  bit_cnt;
  logic [10:0] shreg;
  logic        load, shift, done, short_err;

  logic        sample_stb;
  logic [9:0]  sample;
  logic [1:0]  idx;
  logic [9:0]  slot0, slot1;
  logic        sync_pend;

  logic        emit;
  logic [1:0]  w_cnt;
  logic [9:0]  s0, s1, s2;

  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    short_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_fs) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_fs) begin
          load      = 1'b1;
          short_err = 1'b1;
        end else begin
          shift = 1'b1;
          if (bit_cnt == 4'd15) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tag bits fall off the top of the 11-bit shifter; only reserved+sample remain at the end.
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      sample_stb <= 1'b0;
      sample     <= '0;
      o_frm_err  <= 1'b0;
    end else begin
      sample_stb <= done;
      o_frm_err  <= short_err | (done & (shreg[10:9] != 2'b00));
      if (load) begin
        shreg   <= {10'd0, i_d};
        bit_cnt <= 4'd1;
      end else if (shift) begin
        shreg   <= {shreg[9:0], i_d};
        bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
      end
      if (done) sample <= {shreg[8:0], i_d};
    end
  end

  always_comb begin
    w_cnt = idx + {1'b0, sample_stb};
    s0    = (sample_stb && idx == 2'd0) ? sample : slot0;
    s1    = (sample_stb && idx == 2'd1) ? sample : slot1;
    s2    = (sample_stb && idx == 2'd2) ? sample : 10'd0;
    emit  = (sample_stb && idx == 2'd2) || (i_sync && w_cnt != 2'd0);
  end

  // A scan restart clears count and overflow one cycle late so the flush word counts in the old scan.
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      slot0      <= '0;
      slot1      <= '0;
      sync_pend  <= 1'b0;
      o_vld      <= 1'b0;
      o_data     <= '0;
      o_word_cnt <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_vld     <= 1'b0;
      sync_pend <= i_sync;
      if (emit) begin
        idx   <= 2'd0;
        slot0 <= '0;
        slot1 <= '0;
        if (o_word_cnt == CNT_W'(MAX_WORDS)) begin
          o_ovf <= 1'b1;
        end else begin
          o_vld      <= 1'b1;
          o_data     <= {w_cnt, s2, s1, s0};
          o_word_cnt <= o_word_cnt + CNT_W'(1);
        end
      end else if (sample_stb) begin
        idx <= idx + 2'd1;
        if (idx == 2'd0) slot0 <= sample;
        if (idx == 2'd1) slot1 <= sample;
      end
      if (sync_pend) begin
        o_word_cnt <= '0;
        o_ovf      <= 1'b0;
      end
    end
  end

endmodule
